step_pulser: RTL and testbench
==============================

STEP_PULSER -- requirements
Module: step_pulser

Interface
REQ-001 SHALL have parameter PulseWidth, default 8: number of clk cycles step_out is held high per step (valid range 1..255).
REQ-002 SHALL have parameter DirSetup, default 4: number of clk cycles dir_out is held stable before the first step after a direction change (valid range 1..255).
REQ-003 SHALL have port clk  input  1  the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_available  input  1  the upstream fifo holds at least one complete segment.
REQ-006 SHALL have port data_request  output  1  one-cycle pop strobe to the upstream fifo.
REQ-007 SHALL have port data  input  32  segment word, valid in the cycle after data_request: [31] direction, [30:16] step count, [15:0] step period in clk cycles.
REQ-008 SHALL have port step_out  output  1  step pulse to the motor driver, active high.
REQ-009 SHALL have port dir_out  output  1  direction to the motor driver.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port position  output  32  signed step position; present regardless of configuration.

Function
REQ-012 SHALL implement the states IDLE, FETCH, SETUP, HIGH and LOW.
REQ-013 SHALL drive data_request combinationally as (state==IDLE && data_available), so it is high for exactly one cycle per segment; next state is FETCH.
REQ-014 SHALL, in FETCH, latch dir, count and period from data; with count==0 go to IDLE with no pulse and no dir_out change (segment discarded).
REQ-015 SHALL, in FETCH with count>0, update dir_out to the new direction; if it differs from the previous dir_out go to SETUP for DirSetup cycles, else go directly to HIGH.
REQ-016 SHALL hold step_out=1 for exactly PulseWidth cycles in HIGH, decrement count once on HIGH exit, then enter LOW.
REQ-017 SHALL set the step period (rising edge to rising edge within one segment) to max(period, PulseWidth+1) cycles; periods below PulseWidth+1, including 0, are clamped with no error.
REQ-018 SHALL, at LOW exit, go to HIGH if count>0, otherwise to IDLE.
REQ-019 SHALL produce first-step latency of 2 cycles from the data_request cycle (request T0, FETCH T1, step_out high T2) when there is no direction change, plus DirSetup cycles when there is one.
REQ-020 SHALL add exactly 2 cycles (IDLE + FETCH) between the last LOW cycle of one segment and the HIGH of the next when data_available is already high; with data_available low, stay in IDLE with step_out=0.
REQ-021 SHALL never change dir_out while in HIGH or LOW.
REQ-022 SHALL ignore data_available and data outside IDLE and FETCH.

Reset
REQ-023 SHALL, on rst high, immediately force state=IDLE, step_out=0, dir_out=0, busy=0, data_request=0, position=0, and internal count/period/timers to 0, regardless of the current state.
REQ-024 SHALL drop a pulse truncated by reset mid-HIGH and lose the in-flight segment; there is no resume.
REQ-025 SHALL, after rst deasserts, make its first data_request no earlier than the first rising edge of clk.

Configuration
REQ-026 SHALL, with STEP_PULSER_POSITION_EN defined, increment position by 1 when dir_out=1 and decrement it by 1 when dir_out=0, in the cycle step_out rises, with two's-complement wrap at 32 bits.
REQ-027 SHALL, with STEP_PULSER_POSITION_EN undefined, tie position to 0 and generate no counter logic.

Verification
REQ-028 SHALL verify: segment dir=0 count=3 period=20 after reset -> 3 pulses, each 8 cycles high, rising edges 20 cycles apart, first rising edge 2 cycles after data_request; then busy=0.
REQ-029 SHALL verify: segment dir=1 count=2 period=10 after a dir=0 segment -> dir_out toggles in FETCH, first step 4 cycles later, and position (with macro) ends at previous value +2.
REQ-030 SHALL verify: count=0 segment -> exactly one data_request, no step_out pulse, dir_out unchanged, back in IDLE after 2 cycles.
REQ-031 SHALL verify: period=3 with PulseWidth=8 -> step period clamped to 9 cycles.
REQ-032 SHALL verify: two queued segments of count=1 period=12 -> second rising edge 14 cycles after the first.
REQ-033 SHALL verify: rst asserted in the 4th cycle of HIGH -> step_out=0 and busy=0 in the same cycle, position=0, and the next data_available restarts from IDLE.

Source files
------------

// File: rtl/step_pulser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | step_pulser: pops step segments from a fifo and emits step/dir pulses.   |
// | Optional position counter enabled by defining STEP_PULSER_POSITION_EN.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module step_pulser #(
  parameter int unsigned PulseWidth = 8,
  parameter int unsigned DirSetup   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_available,
  output logic        data_request,
  input  logic [31:0] data,
  output logic        step_out,
  output logic        dir_out,
  output logic        busy,
  output logic [31:0] position
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SETUP = 3'd2,
    S_HIGH  = 3'd3,
    S_LOW   = 3'd4
  } state_t;

  localparam logic [15:0] c_pulse_width = 16'(PulseWidth);
  localparam logic [15:0] c_high_load   = 16'(PulseWidth - 1);
  localparam logic [15:0] c_setup_load  = 16'(DirSetup - 1);

  state_t      r_state, w_state_next;
  logic        r_armed;
  logic        r_dir, w_dir_next;
  logic [14:0] r_count, w_count_next;
  logic [15:0] r_low_len, w_low_len_next;
  logic [15:0] r_timer, w_timer_next;

  logic        w_new_dir;
  logic [14:0] w_new_count;
  logic [15:0] w_new_period;

  assign w_new_dir    = data[31];
  assign w_new_count  = data[30:16];
  assign w_new_period = data[15:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_armed   <= 1'b0;
      r_dir     <= 1'b0;
      r_count   <= '0;
      r_low_len <= '0;
      r_timer   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_armed   <= 1'b1;
      r_dir     <= w_dir_next;
      r_count   <= w_count_next;
      r_low_len <= w_low_len_next;
      r_timer   <= w_timer_next;
    end
  end

  // r_armed holds off the first request until a clock edge after reset release.
  always_comb begin
    w_state_next   = r_state;
    w_dir_next     = r_dir;
    w_count_next   = r_count;
    w_low_len_next = r_low_len;
    w_timer_next   = r_timer;
    data_request   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (data_available && r_armed) begin
          data_request = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        if (w_new_count == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_dir_next   = w_new_dir;
          w_count_next = w_new_count;
          // Low phase length = max(period, PulseWidth+1) - PulseWidth.
          w_low_len_next = (w_new_period > c_pulse_width) ?
                           (w_new_period - c_pulse_width) : 16'd1;
          if (w_new_dir != r_dir) begin
            w_state_next = S_SETUP;
            w_timer_next = c_setup_load;
          end else begin
            w_state_next = S_HIGH;
            w_timer_next = c_high_load;
          end
        end
      end
      S_SETUP: begin
        if (r_timer == '0) begin
          w_state_next = S_HIGH;
          w_timer_next = c_high_load;
        end else begin
          w_timer_next = r_timer - 16'd1;
        end
      end
      S_HIGH: begin
        if (r_timer == '0) begin
          w_state_next = S_LOW;
          w_timer_next = r_low_len - 16'd1;
          w_count_next = r_count - 15'd1;
        end else begin
          w_timer_next = r_timer - 16'd1;
        end
      end
      S_LOW: begin
        if (r_timer == '0) begin
          if (r_count != '0) begin
            w_state_next = S_HIGH;
            w_timer_next = c_high_load;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_timer_next = r_timer - 16'd1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign step_out = (r_state == S_HIGH);
  assign dir_out  = r_dir;
  assign busy     = (r_state != S_IDLE);

`ifdef STEP_PULSER_POSITION_EN
  logic [31:0] r_position;
  logic        w_step_rise;

  assign w_step_rise = (w_state_next == S_HIGH) && (r_state != S_HIGH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_position <= '0;
    end else if (w_step_rise) begin
      r_position <= w_dir_next ? (r_position + 32'd1) : (r_position - 32'd1);
    end
  end

  assign position = r_position;
`else
  assign position = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_step_pulser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_step_pulser: directed and random segments against a timeline model.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_step_pulser;

  localparam int PW    = 8;
  localparam int DS    = 4;
  localparam int LIMIT = 5000;

  typedef struct {
    int          cyc;
    logic        dir;
    logic [31:0] pos;
  } rise_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_available;
  logic        data_request;
  logic [31:0] data;
  logic        step_out;
  logic        dir_out;
  logic        busy;
  logic [31:0] position;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] batch_q[$];
  int          req_q[$];
  int          exp_req[$];
  rise_t       rise_q[$];
  rise_t       exp_rise[$];
  int          width_q[$];

  logic        prev_step = 1'b0;
  logic        prev_dir  = 1'b0;
  int          high_len  = 0;
  logic        model_dir = 1'b0;
  logic [31:0] model_pos = '0;

  step_pulser #(.PulseWidth(PW), .DirSetup(DS)) dut (
    .clk            (clk),
    .rst            (rst),
    .data_available (data_available),
    .data_request   (data_request),
    .data           (data),
    .step_out       (step_out),
    .dir_out        (dir_out),
    .busy           (busy),
    .position       (position)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: sample outputs at negedge, then act as the fifo after posedge.
  task automatic tick();
    logic req;
    @(negedge clk);
    if (data_request) req_q.push_back(cyc);
    if (step_out && !prev_step) rise_q.push_back('{cyc, dir_out, position});
    if (step_out) begin
      if (prev_step) check("dir_hold_in_pulse", 32'(dir_out), 32'(prev_dir));
      high_len++;
    end else if (prev_step) begin
      width_q.push_back(high_len);
      high_len = 0;
    end
    prev_step = step_out;
    prev_dir  = dir_out;
    req       = data_request;
    @(posedge clk);
    #1;
    cyc++;
    if (req && fifo_q.size() != 0) data = fifo_q.pop_front();
    data_available = (fifo_q.size() != 0);
  endtask

  function automatic logic [31:0] seg(input logic dir, input int count, input int period);
    return {dir, 15'(count), 16'(period)};
  endfunction

  // Timeline model: the fifo stays non-empty until drained, so every segment
  // is requested as soon as the previous one ends.
  task automatic run_batch(input string tag);
    int          t, first, peff, cnt, guard;
    logic        d;
    logic [31:0] w;
    rise_t       r;
    req_q.delete(); rise_q.delete(); width_q.delete();
    exp_req.delete(); exp_rise.delete();
    t = cyc;
    foreach (batch_q[k]) begin
      w   = batch_q[k];
      d   = w[31];
      cnt = int'(w[30:16]);
      exp_req.push_back(t);
      if (cnt == 0) begin
        t += 2;
      end else begin
        peff  = (int'(w[15:0]) > PW) ? int'(w[15:0]) : PW + 1;
        first = t + 2 + ((d != model_dir) ? DS : 0);
        model_dir = d;
        for (int i = 0; i < cnt; i++) begin
          model_pos = d ? model_pos + 32'd1 : model_pos - 32'd1;
          r.cyc = first + i * peff;
          r.dir = d;
`ifdef STEP_PULSER_POSITION_EN
          r.pos = model_pos;
`else
          r.pos = '0;
`endif
          exp_rise.push_back(r);
        end
        t = first + cnt * peff;
      end
    end
    fifo_q = batch_q;
    data_available = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!(fifo_q.size() == 0 && !busy) && guard < LIMIT);
    check({tag, "_done_in_time"}, 32'(guard < LIMIT), 32'd1);
    repeat (3) tick();
    check({tag, "_req_count"}, 32'(req_q.size()), 32'(exp_req.size()));
    for (int i = 0; i < req_q.size() && i < exp_req.size(); i++)
      check({tag, "_req_cycle"}, 32'(req_q[i]), 32'(exp_req[i]));
    check({tag, "_rise_count"}, 32'(rise_q.size()), 32'(exp_rise.size()));
    for (int i = 0; i < rise_q.size() && i < exp_rise.size(); i++) begin
      check({tag, "_rise_cycle"}, 32'(rise_q[i].cyc), 32'(exp_rise[i].cyc));
      check({tag, "_rise_dir"}, 32'(rise_q[i].dir), 32'(exp_rise[i].dir));
      check({tag, "_rise_pos"}, rise_q[i].pos, exp_rise[i].pos);
    end
    check({tag, "_width_count"}, 32'(width_q.size()), 32'(exp_rise.size()));
    foreach (width_q[i]) check({tag, "_pulse_width"}, 32'(width_q[i]), 32'(PW));
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_step"}, 32'(step_out), 32'd0);
    check({tag, "_dir_out"}, 32'(dir_out), 32'(model_dir));
  endtask

  initial begin
    int guard;
    rst            = 1'b1;
    data_available = 1'b0;
    data           = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_step", 32'(step_out), 32'd0);
    check("reset_dir", 32'(dir_out), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_req", 32'(data_request), 32'd0);
    check("reset_pos", position, 32'd0);
    rst = 1'b0;
    tick();

    batch_q = '{seg(1'b0, 3, 20)};
    run_batch("basic");
    batch_q = '{seg(1'b1, 2, 10)};
    run_batch("dir_change");
    batch_q = '{seg(1'b0, 0, 15)};
    run_batch("zero_count");
    batch_q = '{seg(1'b1, 3, 3)};
    run_batch("clamp");
    batch_q = '{seg(1'b1, 1, 12), seg(1'b1, 1, 12)};
    run_batch("back_to_back");
    batch_q = '{seg(1'b0, 2, 0), seg(1'b0, 0, 5), seg(1'b1, 1, 9)};
    run_batch("mixed");

    for (int b = 0; b < 6; b++) begin
      batch_q.delete();
      for (int s = 0; s < int'($urandom_range(1, 4)); s++)
        batch_q.push_back(seg(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                              int'($urandom_range(0, 30))));
      run_batch("random");
    end

    // Reset in the 4th cycle of a pulse.
    fifo_q = '{seg(1'b1, 5, 20)};
    data_available = 1'b1;
    rise_q.delete();
    guard = 0;
    while (rise_q.size() == 0 && guard < LIMIT) begin
      tick();
      guard++;
    end
    check("rst_wait_pulse", 32'(guard < LIMIT), 32'd1);
    repeat (2) tick();
    check("rst_pre_step", 32'(step_out), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_step", 32'(step_out), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_pos", position, 32'd0);
    check("rst_mid_dir", 32'(dir_out), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    model_dir = 1'b0;
    model_pos = '0;
    tick();
    batch_q = '{seg(1'b1, 2, 11)};
    run_batch("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
